// File: rtl/pixel_pair_writer.sv
// Dual-port framebuffer write stage: takes (even, odd) address pairs with colours,
// registers them onto both RAM ports, counts completed pair writes and flags malformed pairs.
module pixel_pair_writer #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PAIRS  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr_a,
    input  logic [ADDR_W-1:0] in_addr_b,
    input  logic [DATA_W-1:0] color_a,
    input  logic [DATA_W-1:0] color_b,
    input  logic              mem_ready,
    output logic              we_a,
    output logic              we_b,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] wdata_b,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [7:0] PAIRS_C = 8'(PAIRS);

    state_e            state_q, state_d;
    logic [7:0]        accepted_q, accepted_d;
    logic [7:0]        written_q, written_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] mem_addr_a_q, mem_addr_a_d;
    logic [ADDR_W-1:0] mem_addr_b_q, mem_addr_b_d;
    logic [DATA_W-1:0] wdata_a_q, wdata_a_d;
    logic [DATA_W-1:0] wdata_b_q, wdata_b_d;

    logic [ADDR_W-1:0] addr_a_inc;
    logic              pair_ok;
    logic              accept;
    logic              write_done;

    always_comb begin
        addr_a_inc = in_addr_a + ADDR_W'(1);
        pair_ok    = !in_addr_a[0] && (in_addr_b == addr_a_inc);
        in_ready   = (state_q == RUN) && (accepted_q < PAIRS_C) && (!out_valid_q || mem_ready);
        accept     = in_valid && in_ready;
        write_done = out_valid_q && mem_ready;
    end

    always_comb begin
        state_d      = state_q;
        accepted_d   = accepted_q;
        written_d    = written_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        mem_addr_a_d = mem_addr_a_q;
        mem_addr_b_d = mem_addr_b_q;
        wdata_a_d    = wdata_a_q;
        wdata_b_d    = wdata_b_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    accepted_d  = '0;
                    written_d   = '0;
                    err_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (write_done) begin
                    written_d   = written_q + 8'd1;
                    out_valid_d = 1'b0;
                end
                // A load in the same cycle as a completion keeps out_valid high.
                if (accept) begin
                    if (pair_ok) begin
                        mem_addr_a_d = in_addr_a;
                        mem_addr_b_d = in_addr_b;
                        wdata_a_d    = color_a;
                        wdata_b_d    = color_b;
                        out_valid_d  = 1'b1;
                        accepted_d   = accepted_q + 8'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (written_d == PAIRS_C) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            accepted_q   <= '0;
            written_q    <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            mem_addr_a_q <= '0;
            mem_addr_b_q <= '0;
            wdata_a_q    <= '0;
            wdata_b_q    <= '0;
        end else begin
            state_q      <= state_d;
            accepted_q   <= accepted_d;
            written_q    <= written_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            mem_addr_a_q <= mem_addr_a_d;
            mem_addr_b_q <= mem_addr_b_d;
            wdata_a_q    <= wdata_a_d;
            wdata_b_q    <= wdata_b_d;
        end
    end

    always_comb begin
        we_a       = out_valid_q;
        we_b       = out_valid_q;
        mem_addr_a = mem_addr_a_q;
        mem_addr_b = mem_addr_b_q;
        wdata_a    = wdata_a_q;
        wdata_b    = wdata_b_q;
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
        err        = err_q;
    end

endmodule

// File: tb/tb_pixel_pair_writer.sv
// Self-checking bench for pixel_pair_writer: random valid/ready timing against an
// expected-write queue built from the pair-validity rule.
module tb_pixel_pair_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_addr_a = '0;
    logic [13:0] in_addr_b = '0;
    logic [7:0]  color_a = '0;
    logic [7:0]  color_b = '0;
    logic        mem_ready = 1'b0;
    logic        we_a, we_b;
    logic [13:0] mem_addr_a, mem_addr_b;
    logic [7:0]  wdata_a, wdata_b;
    logic        busy, done, err;

    pixel_pair_writer #(.ADDR_W(14), .DATA_W(8), .PAIRS(128)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr_a(in_addr_a), .in_addr_b(in_addr_b), .color_a(color_a), .color_b(color_b),
        .mem_ready(mem_ready), .we_a(we_a), .we_b(we_b), .mem_addr_a(mem_addr_a),
        .mem_addr_b(mem_addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [13:0] st_a[$], st_b[$];
    logic [7:0]  st_ca[$], st_cb[$];
    logic [43:0] exp_w[$], obs_w[$];

    int   done_cycle, done_count, stall_cycles, stall_bad, extra_acc, we_mismatch, err_drop;
    logic err_end, busy_end, busy_k1, ready_k1, err_k1;

    // Offered pair; it is expected as a write only if it is a well-formed (even, even+1) pair.
    task automatic push_pair(input logic [13:0] a, input logic [13:0] b);
        logic [7:0]  ca, cb;
        logic [13:0] a1;
        ca = 8'($urandom);
        cb = 8'($urandom);
        a1 = a + 14'd1;
        st_a.push_back(a); st_b.push_back(b); st_ca.push_back(ca); st_cb.push_back(cb);
        if (a[0] == 1'b0 && b == a1) exp_w.push_back({a, b, ca, cb});
    endtask

    task automatic build_stim(input bit bad);
        st_a.delete(); st_b.delete(); st_ca.delete(); st_cb.delete(); exp_w.delete();
        for (int i = 0; i < 128; i++) begin
            push_pair(14'(3584 + 2 * i), 14'(3585 + 2 * i));
            if (bad && i == 10) push_pair(14'd3601, 14'd3602);
            if (bad && i == 40) push_pair(14'd3600, 14'd3605);
        end
    endtask

    // Drives one run from a start pulse and records what the DUT did.
    task automatic run(input bit rnd_valid, input bit rnd_ready, input bit bp,
                       input int stop_writes, input bit hold_valid, input int s1, input int s2);
        int k, sp, stall_left;
        bit bp_done, err_seen;
        obs_w.delete();
        done_cycle = -1; done_count = 0; stall_cycles = 0; stall_bad = 0;
        extra_acc = 0; we_mismatch = 0; err_drop = 0;
        k = 0; sp = 0; stall_left = 0; bp_done = 0; err_seen = 0;
        @(negedge clk);
        start = 1'b1;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            start = (k == s1 || k == s2);
            if (sp < st_a.size()) begin
                in_valid  = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_addr_a = st_a[sp]; in_addr_b = st_b[sp];
                color_a   = st_ca[sp]; color_b = st_cb[sp];
            end else if (hold_valid) begin
                in_valid = 1'b1; in_addr_a = 14'd4000; in_addr_b = 14'd4001;
            end else begin
                in_valid = 1'b0;
            end
            if (stall_left > 0) begin
                mem_ready = 1'b0; stall_left--;
            end else if (bp && !bp_done && we_a && mem_addr_a == 14'd3600) begin
                mem_ready = 1'b0; stall_left = 2; bp_done = 1;
            end else begin
                mem_ready = rnd_ready ? ($urandom_range(0, 4) != 0) : 1'b1;
            end
            #1;
            if (bp && !mem_ready) begin
                stall_cycles++;
                if (we_a !== 1'b1 || mem_addr_a !== 14'd3600 || mem_addr_b !== 14'd3601 || in_ready !== 1'b0)
                    stall_bad++;
            end
            if (k == 1) begin busy_k1 = busy; ready_k1 = in_ready; err_k1 = err; end
            if (err === 1'b1) err_seen = 1; else if (err_seen) err_drop++;
            if (done === 1'b1) begin
                done_count++;
                if (done_cycle < 0) done_cycle = k;
            end
            if (we_a !== we_b) we_mismatch++;
            if (in_valid && in_ready === 1'b1) begin
                if (sp < st_a.size()) sp++; else extra_acc++;
            end
            if (we_a === 1'b1 && mem_ready) obs_w.push_back({mem_addr_a, mem_addr_b, wdata_a, wdata_b});
            if (stop_writes > 0 && obs_w.size() >= stop_writes) break;
            if (done_cycle >= 0 && k >= done_cycle + 2) break;
        end
        err_end = err; busy_end = busy;
        in_valid = 1'b0; start = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        repeat (2) @(negedge clk);
        outs = 64'({in_ready, we_a, we_b, mem_addr_a, mem_addr_b, wdata_a, wdata_b, busy, done, err});
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h expected 0", outs); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_no_ready got in_ready=%b busy=%b expected 0 0", in_ready, busy);
        end
    endtask

    task automatic test_nominal();
        int nbad;
        build_stim(0);
        run(0, 0, 0, 0, 0, 0, 0);
        nbad = 0;
        for (int i = 0; i < exp_w.size(); i++)
            if (i >= obs_w.size() || obs_w[i] !== exp_w[i]) nbad++;
        checks++;
        if (obs_w.size() != exp_w.size() || nbad != 0) begin
            errors++; $display("FAIL nominal_writes got %0d writes (%0d wrong) expected %0d", obs_w.size(), nbad, exp_w.size());
        end
        checks++;
        if (busy_k1 !== 1'b1 || ready_k1 !== 1'b1) begin
            errors++; $display("FAIL start_latency got busy=%b in_ready=%b expected 1 1", busy_k1, ready_k1);
        end
        checks++;
        if (done_cycle != 130 || done_count != 1) begin
            errors++; $display("FAIL nominal_done got cycle %0d count %0d expected 130 1", done_cycle, done_count);
        end
        checks++;
        if (err_end !== 1'b0 || busy_end !== 1'b0 || we_mismatch != 0) begin
            errors++; $display("FAIL nominal_end got err=%b busy=%b we_mismatch=%0d expected 0 0 0", err_end, busy_end, we_mismatch);
        end
    endtask

    task automatic test_backpressure();
        int nbad;
        build_stim(0);
        run(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (stall_cycles != 3 || stall_bad != 0) begin
            errors++; $display("FAIL bp_frozen got %0d stall cycles, %0d bad expected 3 0", stall_cycles, stall_bad);
        end
        nbad = 0;
        for (int i = 0; i < exp_w.size(); i++)
            if (i >= obs_w.size() || obs_w[i] !== exp_w[i]) nbad++;
        checks++;
        if (obs_w.size() != exp_w.size() || nbad != 0) begin
            errors++; $display("FAIL bp_writes got %0d writes (%0d wrong) expected %0d", obs_w.size(), nbad, exp_w.size());
        end
        checks++;
        if (done_cycle != 133 || done_count != 1) begin
            errors++; $display("FAIL bp_done got cycle %0d count %0d expected 133 1", done_cycle, done_count);
        end
    endtask

    task automatic test_malformed();
        int nbad;
        build_stim(1);
        run(1, 1, 0, 0, 0, 0, 0);
        nbad = 0;
        for (int i = 0; i < exp_w.size(); i++)
            if (i >= obs_w.size() || obs_w[i] !== exp_w[i]) nbad++;
        checks++;
        if (obs_w.size() != exp_w.size() || nbad != 0) begin
            errors++; $display("FAIL bad_writes got %0d writes (%0d wrong) expected %0d", obs_w.size(), nbad, exp_w.size());
        end
        checks++;
        if (err_end !== 1'b1 || err_drop != 0 || done_count != 1) begin
            errors++; $display("FAIL bad_err got err=%b drops=%0d done=%0d expected 1 0 1", err_end, err_drop, done_count);
        end
        build_stim(0);
        run(1, 1, 0, 0, 0, 0, 0);
        nbad = 0;
        for (int i = 0; i < exp_w.size(); i++)
            if (i >= obs_w.size() || obs_w[i] !== exp_w[i]) nbad++;
        checks++;
        if (obs_w.size() != exp_w.size() || nbad != 0) begin
            errors++; $display("FAIL rerun_writes got %0d writes (%0d wrong) expected %0d", obs_w.size(), nbad, exp_w.size());
        end
        checks++;
        if (err_k1 !== 1'b0 || err_end !== 1'b0 || done_count != 1) begin
            errors++; $display("FAIL err_clear got err_k1=%b err_end=%b done=%0d expected 0 0 1", err_k1, err_end, done_count);
        end
    endtask

    task automatic test_reset_midrun();
        logic [63:0] outs;
        int nbad, late_done;
        build_stim(0);
        run(1, 1, 0, 50, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        outs = 64'({in_ready, we_a, we_b, mem_addr_a, mem_addr_b, wdata_a, wdata_b, busy, done, err});
        checks++;
        if (outs !== '0 || done_count != 0) begin
            errors++; $display("FAIL midrun_reset got %h done_count %0d expected 0 0", outs, done_count);
        end
        @(negedge clk);
        reset = 1'b1;
        late_done = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || in_ready !== 1'b0 || we_a !== 1'b0) late_done++;
        end
        checks++;
        if (late_done != 0) begin errors++; $display("FAIL post_reset_quiet got %0d active cycles expected 0", late_done); end
        build_stim(0);
        run(0, 0, 0, 0, 0, 0, 0);
        nbad = 0;
        for (int i = 0; i < exp_w.size(); i++)
            if (i >= obs_w.size() || obs_w[i] !== exp_w[i]) nbad++;
        checks++;
        if (obs_w.size() != exp_w.size() || nbad != 0 || done_cycle != 130) begin
            errors++; $display("FAIL after_reset_run got %0d writes (%0d wrong) done %0d expected %0d 0 130", obs_w.size(), nbad, done_cycle, exp_w.size());
        end
    endtask

    task automatic test_start_while_busy();
        build_stim(0);
        run(0, 0, 0, 0, 1, 20, 130);
        checks++;
        if (extra_acc != 0 || obs_w.size() != 128) begin
            errors++; $display("FAIL no_extra got %0d extra accepts %0d writes expected 0 128", extra_acc, obs_w.size());
        end
        checks++;
        if (done_cycle != 130 || done_count != 1 || busy_end !== 1'b0) begin
            errors++; $display("FAIL start_ignored got done %0d count %0d busy=%b expected 130 1 0", done_cycle, done_count, busy_end);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_malformed();
        test_reset_midrun();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_pair_writer.md
# pixel_pair_writer

Downstream stage of the draw address-pair counter. Accepts a stream of (even, odd) 14-bit framebuffer address pairs with valid/ready, attaches per-port pixel colours, and issues simultaneous writes on both ports of the dual-port framebuffer RAM. It counts completed pair writes, raises a one-cycle `done` after a programmed number of pairs, and flags malformed pairs instead of writing them.

## Interface
- `ADDR_W`, 14, framebuffer address width (pair addresses carry LSB 0 / 1)
- `DATA_W`, 8, pixel data width per port
- `PAIRS`, 128, pair writes per run (1..255)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  one-cycle pulse; begins a run from IDLE, ignored otherwise
- `in_valid`  in  1  upstream pair valid
- `in_ready`  out  1  stage can accept a pair this cycle
- `in_addr_a`  in  ADDR_W  even address (LSB must be 0)
- `in_addr_b`  in  ADDR_W  odd address (must equal `in_addr_a` + 1)
- `color_a`, `color_b`  in  DATA_W  pixel data sampled with the pair
- `mem_ready`  in  1  RAM accepts the presented write this cycle
- `we_a`, `we_b`  out  1  write enables, port A / B
- `mem_addr_a`, `mem_addr_b`  out  ADDR_W  registered write addresses
- `wdata_a`, `wdata_b`  out  DATA_W  registered write data
- `busy`  out  1  state is RUN
- `done`  out  1  one-cycle pulse, run complete
- `err`  out  1  sticky: malformed pair seen this run

## Operation
- States: IDLE, RUN, DONE. IDLE -start-> RUN; RUN -(written == PAIRS)-> DONE; DONE -> IDLE unconditionally.
- Entering RUN clears `accepted`, `written` (8-bit each) and `err`.
- Accept = `in_valid && in_ready`. `in_ready` = (state == RUN) && (`accepted` < PAIRS) && (!`out_valid` || `mem_ready`).
- On accept: check `in_addr_a[0] == 0` and `in_addr_b == in_addr_a + 1` (ADDR_W-bit add, wrap allowed, no wrap pair is valid since LSB of a is 0).
  - Valid pair: load output register (addresses, colours), set `out_valid`, `accepted` += 1.
  - Malformed pair: set `err`, consume (handshake completes), do not load output, do not count.
- `we_a` = `we_b` = `out_valid`. Output register holds while `mem_ready` = 0. Write completes on `out_valid && mem_ready`: `written` += 1; `out_valid` clears unless a new pair loads the same cycle.
- Simultaneous completion and accept: register reloads, `out_valid` stays 1, both counters increment.
- `done` asserted for the single DONE cycle; `err` holds through DONE and IDLE until next `start`.
- `start` in RUN or DONE ignored.
- Reset (any state, mid-run included): state IDLE; all outputs 0 (`in_ready`, `we_a`, `we_b`, `mem_addr_*`, `wdata_*`, `busy`, `done`, `err`); counters 0; in-flight pair discarded.

## Timing
- Accept-to-write latency: 1 cycle (pair accepted at edge N is presented with `we_*` high in cycle N+1).
- Throughput: one pair per cycle with `mem_ready` held 1.
- `start` at edge N: `busy` and `in_ready` high from cycle N+1.
- Last write completes at edge M: state DONE, `done` = 1 during cycle M+1; IDLE and `busy` = 0 at M+2.
- Minimum run with PAIRS = 128 and no stalls: start edge to `done` = 130 cycles.
- `mem_ready` low for k cycles: outputs frozen k cycles, `in_ready` low while `out_valid` = 1.

## Test plan
- Reset: assert `reset` = 0 asynchronously mid-cycle -> all outputs 0 immediately, state IDLE; release, `in_ready` stays 0 until `start`.
- Nominal run: PAIRS = 128, stream (3584,3585)…(3838,3839), `mem_ready` = 1 -> 128 writes, addresses match one cycle after accept, `done` pulse 130 cycles after `start`, `err` = 0.
- Backpressure: drop `mem_ready` for 3 cycles on pair (3600,3601) -> `we_*`, `mem_addr_*` frozen 3 cycles, `in_ready` = 0, no pair lost or duplicated, `written` ends at 128.
- Malformed: inject (3601,3602) and (3600,3605) -> both consumed, no write, `err` = 1 sticky, run finishes after 128 valid pairs; next `start` clears `err`.
- Reset mid-run: reset after 50 writes -> outputs 0, no `done`; new `start` completes a full 128-pair run.
- `start` while busy and `in_valid` held high after `accepted` = PAIRS -> `start` ignored, `in_ready` = 0, no extra writes.
